decimal_key_entry: RTL and testbench

DECIMAL_KEY_ENTRY -- requirements
Module: decimal_key_entry

---
 rtl/decimal_key_entry_if.sv | 37 +++
 rtl/decimal_key_entry.sv | 158 +++++++++++++++
 tb/tb_decimal_key_entry.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decimal_key_entry_if.sv
// Key-entry bus: strobed PS/2 scan-code bytes in, committed value out.
// Ports: key_code/key_valid (in), value, value_valid, digit_count,
//        busy, overflow_err (out). master = key source, slave = block.
interface decimal_key_entry_if #(
   parameter int N_DIGITS = 2,
   parameter int OUT_W    = 7
);
   localparam int CW = $clog2(N_DIGITS + 1);

   logic [7:0]       key_code;
   logic             key_valid;
   logic [OUT_W-1:0] value;
   logic             value_valid;
   logic [CW-1:0]    digit_count;
   logic             busy;
   logic             overflow_err;

   modport master (
      output key_code,
      output key_valid,
      input  value,
      input  value_valid,
      input  digit_count,
      input  busy,
      input  overflow_err
   );

   modport slave (
      input  key_code,
      input  key_valid,
      output value,
      output value_valid,
      output digit_count,
      output busy,
      output overflow_err
   );
endinterface

// File: rtl/decimal_key_entry.sv
// PS/2 set-2 decimal entry: buffers digits, converts to binary on Enter.
// Ports: clk, reset (async active-low), kif (slave side of key bus).
module decimal_key_entry #(
   parameter int N_DIGITS = 2,
   parameter int OUT_W    = 7
) (
   input logic                clk,
   input logic                reset,
   decimal_key_entry_if.slave kif
);
   localparam int CW = $clog2(N_DIGITS + 1);
   localparam int BW = 4 * N_DIGITS;
   localparam logic [OUT_W-1:0] TEN = OUT_W'(10);

   typedef enum logic [1:0] {
      MAKE,
      BREAK,
      EXT,
      CONV
   } state_t;

   state_t           r_state;
   logic [BW-1:0]    r_buf;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    r_rem;
   logic [OUT_W-1:0] r_acc;
   logic [OUT_W-1:0] r_value;
   logic             r_valid;
   logic             r_busy;
   logic             r_ovf;

   logic             w_is_dig;
   logic [3:0]       w_dig;
   logic             w_f0;
   logic             w_e0;
   logic             w_bs;
   logic             w_esc;
   logic             w_ent;
   logic [CW-1:0]    w_idx;
   logic [3:0]       w_cur;

   always_comb begin
      w_is_dig = 1'b1;
      w_dig    = 4'd0;
      unique case (kif.key_code)
         8'h45:   w_dig = 4'd0;
         8'h16:   w_dig = 4'd1;
         8'h1E:   w_dig = 4'd2;
         8'h26:   w_dig = 4'd3;
         8'h25:   w_dig = 4'd4;
         8'h2E:   w_dig = 4'd5;
         8'h36:   w_dig = 4'd6;
         8'h3D:   w_dig = 4'd7;
         8'h3E:   w_dig = 4'd8;
         8'h46:   w_dig = 4'd9;
         default: w_is_dig = 1'b0;
      endcase
   end

   assign w_f0  = (kif.key_code == 8'hF0);
   assign w_e0  = (kif.key_code == 8'hE0);
   assign w_bs  = (kif.key_code == 8'h66);
   assign w_esc = (kif.key_code == 8'h76);
   assign w_ent = (kif.key_code == 8'h5A);

   // Nibble 0 is the newest digit, so the oldest pending digit
   // during conversion sits at position r_rem-1.
   assign w_idx = r_rem - CW'(1);

   always_comb begin
      w_cur = 4'd0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (w_idx == CW'(i)) w_cur = r_buf[4*i +: 4];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= MAKE;
         r_buf   <= '0;
         r_cnt   <= '0;
         r_rem   <= '0;
         r_acc   <= '0;
         r_value <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_ovf   <= 1'b0;
         unique case (r_state)
            CONV: begin
               // k accumulate edges, then one commit edge.
               if (r_rem != '0) begin
                  r_acc <= r_acc * TEN + OUT_W'(w_cur);
                  r_rem <= w_idx;
               end else begin
                  r_value <= r_acc;
                  r_valid <= 1'b1;
                  r_buf   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= MAKE;
               end
            end
            BREAK: begin
               if (kif.key_valid) r_state <= MAKE;
            end
            EXT: begin
               if (kif.key_valid) begin
                  r_state <= w_f0 ? BREAK : MAKE;
               end
            end
            MAKE: begin
               if (kif.key_valid) begin
                  unique case (1'b1)
                     w_f0: r_state <= BREAK;
                     w_e0: r_state <= EXT;
                     w_is_dig: begin
                        if (r_cnt == CW'(N_DIGITS)) begin
                           r_ovf <= 1'b1;
                        end else begin
                           r_buf <= (r_buf << 4) | BW'(w_dig);
                           r_cnt <= r_cnt + CW'(1);
                        end
                     end
                     w_bs: begin
                        if (r_cnt != '0) begin
                           r_buf <= r_buf >> 4;
                           r_cnt <= r_cnt - CW'(1);
                        end
                     end
                     w_esc: begin
                        r_buf <= '0;
                        r_cnt <= '0;
                     end
                     w_ent: begin
                        if (r_cnt != '0) begin
                           r_rem   <= r_cnt;
                           r_acc   <= '0;
                           r_busy  <= 1'b1;
                           r_state <= CONV;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

   assign kif.value        = r_value;
   assign kif.value_valid  = r_valid;
   assign kif.digit_count  = r_cnt;
   assign kif.busy         = r_busy;
   assign kif.overflow_err = r_ovf;
endmodule

// File: tb/tb_decimal_key_entry.sv
// Bench for decimal_key_entry: two sizes driven in lockstep,
// checked against a digit-list reference model.
module tb_decimal_key_entry;
   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] kc    = 8'h00;
   logic       kv    = 1'b0;

   always #5 clk = ~clk;

   decimal_key_entry_if #(.N_DIGITS(2), .OUT_W(7))  if0();
   decimal_key_entry_if #(.N_DIGITS(4), .OUT_W(14)) if1();

   assign if0.key_code  = kc;
   assign if0.key_valid = kv;
   assign if1.key_code  = kc;
   assign if1.key_valid = kv;

   decimal_key_entry #(.N_DIGITS(2), .OUT_W(7)) u0 (
      .clk   (clk),
      .reset (reset),
      .kif   (if0)
   );

   decimal_key_entry #(.N_DIGITS(4), .OUT_W(14)) u1 (
      .clk   (clk),
      .reset (reset),
      .kif   (if1)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d @%0t",
                  tag, got, exp, $time);
      end
   endtask

   // Reference model: a list of digits (oldest first) per unit.
   int  cap [2] = '{2, 4};
   int  mdig[2][9];
   int  mn  [2];
   bit  mbrk[2];
   bit  mext[2];
   bit  mbusy[2];
   int  mleft[2];
   int  mpend[2];
   int  mval[2];
   bit  mvv[2];
   bit  movf[2];

   logic [7:0] codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                             8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   function automatic int dig_of(input logic [7:0] c);
      for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         mn[u] = 0; mbrk[u] = 0; mext[u] = 0; mbusy[u] = 0;
         mleft[u] = 0; mpend[u] = 0; mval[u] = 0;
         mvv[u] = 0; movf[u] = 0;
      end
   endtask

   task automatic model_edge(input int u, input bit v,
                             input logic [7:0] c);
      int d;
      d = dig_of(c);
      mvv[u]  = 0;
      movf[u] = 0;
      if (mbusy[u]) begin
         mleft[u]--;
         if (mleft[u] == 0) begin
            mval[u]  = mpend[u];
            mvv[u]   = 1;
            mbusy[u] = 0;
            mn[u]    = 0;
         end
      end else if (v) begin
         if (mbrk[u]) mbrk[u] = 0;
         else if (mext[u]) begin
            mext[u] = 0;
            if (c == 8'hF0) mbrk[u] = 1;
         end
         else if (c == 8'hF0) mbrk[u] = 1;
         else if (c == 8'hE0) mext[u] = 1;
         else if (d >= 0) begin
            if (mn[u] < cap[u]) begin
               mdig[u][mn[u]] = d;
               mn[u]++;
            end else movf[u] = 1;
         end
         else if (c == 8'h66) begin
            if (mn[u] > 0) mn[u]--;
         end
         else if (c == 8'h76) mn[u] = 0;
         else if (c == 8'h5A && mn[u] > 0) begin
            mpend[u] = 0;
            for (int i = 0; i < mn[u]; i++)
               mpend[u] = mpend[u] * 10 + mdig[u][i];
            mleft[u] = mn[u] + 1;
            mbusy[u] = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("u0.value", 32'(if0.value),       mval[0]);
      chk("u0.vv",    32'(if0.value_valid), 32'(mvv[0]));
      chk("u0.cnt",   32'(if0.digit_count), mn[0]);
      chk("u0.busy",  32'(if0.busy),        32'(mbusy[0]));
      chk("u0.ovf",   32'(if0.overflow_err),32'(movf[0]));
      chk("u1.value", 32'(if1.value),       mval[1]);
      chk("u1.vv",    32'(if1.value_valid), 32'(mvv[1]));
      chk("u1.cnt",   32'(if1.digit_count), mn[1]);
      chk("u1.busy",  32'(if1.busy),        32'(mbusy[1]));
      chk("u1.ovf",   32'(if1.overflow_err),32'(movf[1]));
   endtask

   task automatic step(input bit v, input logic [7:0] c);
      kv = v;
      kc = c;
      @(posedge clk);
      model_edge(0, v, c);
      model_edge(1, v, c);
      #1;
      check_all();
   endtask

   task automatic key(input logic [7:0] c);
      step(1'b1, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      reset = 1'b1;
   endtask

   initial begin
      int r;
      model_reset();
      #1;
      check_all();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      check_all();

      // Make/break pairs for 2 and 5, then Enter.
      key(8'h1E); key(8'hF0); key(8'h1E);
      key(8'h2E); key(8'hF0); key(8'h2E);
      key(8'h5A);
      idle(3);
      chk("r029.u0.value", 32'(if0.value), 25);
      chk("r029.u0.vv",    32'(if0.value_valid), 1);
      chk("r029.u0.cnt",   32'(if0.digit_count), 0);

      // Third digit overflows the 2-digit unit only.
      key(8'h16); key(8'h26); key(8'h25);
      key(8'h5A);
      idle(4);
      chk("r030.u0.value", 32'(if0.value), 13);
      chk("r030.u1.value", 32'(if1.value), 134);

      // Backspace replaces 7 with 6; then backspace on empty.
      key(8'h46); key(8'h3D); key(8'h66); key(8'h36);
      key(8'h5A);
      idle(3);
      chk("r031.u0.value", 32'(if0.value), 96);
      key(8'h66);
      idle(1);
      chk("r031.bs0.cnt", 32'(if1.digit_count), 0);

      // Extended and released keys never enter digits.
      key(8'hE0); key(8'h16);
      key(8'hF0); key(8'h26);
      key(8'h5A);
      idle(2);
      chk("r032.cnt", 32'(if1.digit_count), 0);
      chk("r032.value", 32'(if1.value), 96);

      // 8765 with a key strobed mid-conversion.
      key(8'h3E); key(8'h3D); key(8'h36); key(8'h2E);
      key(8'h5A);
      idle(1); key(8'h16); idle(3);
      chk("r033.u1.value", 32'(if1.value), 8765);
      chk("r033.u1.vv",    32'(if1.value_valid), 1);
      chk("r033.u0.value", 32'(if0.value), 87);
      idle(2);

      // Leading zero, reset mid-conversion, then a fresh entry.
      key(8'h45); key(8'h2E); key(8'h5A);
      idle(1);
      do_reset();
      idle(4);
      key(8'h16); key(8'h5A);
      idle(2);
      chk("r034.u0.value", 32'(if0.value), 1);
      chk("r034.u1.value", 32'(if1.value), 1);

      // Leading zero converts numerically.
      key(8'h45); key(8'h3D); key(8'h5A);
      idle(3);
      chk("r023.u0.value", 32'(if0.value), 7);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            r = $urandom_range(0, 21);
            if (r < 10)       kc = codes[r];
            else if (r == 10) kc = 8'hF0;
            else if (r == 11) kc = 8'hE0;
            else if (r < 15)  kc = 8'h5A;
            else if (r < 17)  kc = 8'h66;
            else if (r == 17) kc = 8'h76;
            else              kc = 8'($urandom);
            step(1'($urandom_range(0, 1)), kc);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end
endmodule
